alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have parameter SIZE, default 16, giving the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N presents an operation.
REQ-005 The module SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operation of requester N is accepted this cycle.
REQ-006 The module SHALL have ports req0_op and req1_op, input, 3 bits each: opcode of requester N.
REQ-007 The module SHALL have ports req0_a, req0_b, req1_a and req1_b, input, SIZE bits each: operands of requester N.
REQ-008 The module SHALL have port rsp_valid, output, 1 bit: a result is presented.
REQ-009 The module SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The module SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-011 The module SHALL have port rsp_result, output, SIZE bits: the registered result.
REQ-012 The module SHALL have port rsp_zero, output, 1 bit: high when rsp_result is all zeros.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 The module SHALL have port op_count, output, 16 bits: number of completed responses.

Function
REQ-015 The FSM SHALL have three states, IDLE, EXEC and RESP, and SHALL remain in each state until its exit condition holds.
REQ-016 In IDLE, when any reqN_valid is high, the FSM SHALL grant exactly one requester, assert that requester's reqN_ready combinationally in that cycle, capture its op, a and b into registers, capture its index into rsp_id, and move to EXEC.
REQ-017 reqN_ready SHALL be low in EXEC and RESP, and SHALL be low for the requester not granted.
REQ-018 Arbitration SHALL be round-robin: when only one requester is valid, that requester is granted.
REQ-019 When both requesters are valid, the requester other than the last-granted one SHALL be granted.
REQ-020 The last-granted pointer SHALL update on each grant, and its reset value SHALL make req0 win the first contention.
REQ-021 In EXEC, the module SHALL compute the result from the captured operands (bitwise, SIZE bits, no carry) into rsp_result and move to RESP after exactly one cycle.
REQ-022 Opcodes SHALL map as: 000 AND; 001 OR; 010 XOR; 011 NOR; 100 NAND; 101 XNOR; 110 ~a (b ignored); 111 a (pass-through).
REQ-023 In RESP, rsp_valid SHALL be high, and rsp_id, rsp_result and rsp_zero SHALL be held stable until rsp_ready is sampled high.
REQ-024 On the cycle rsp_ready is high in RESP, the FSM SHALL return to IDLE and op_count SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-025 Latency SHALL be: accept in cycle T, rsp_valid high in cycle T+2; with rsp_ready held high, the next accept occurs at T+3, giving a minimum of 3 cycles per operation.
REQ-026 Changes on reqN_op, reqN_a or reqN_b after acceptance SHALL NOT affect the in-flight result.
REQ-027 A requester that drops reqN_valid before it is granted SHALL NOT be served.

Reset
REQ-028 When rst_n is low at a rising clk edge, the FSM SHALL go to IDLE.
REQ-029 When rst_n is low at a rising clk edge, rsp_valid, rsp_id, rsp_result and op_count SHALL become 0, rsp_zero SHALL become 1, busy SHALL become 0, and the round-robin pointer SHALL reset so req0 has priority.
REQ-030 A reset in EXEC or RESP SHALL abort the operation with no response and no op_count increment.
REQ-031 While rst_n is low, req0_ready and req1_ready SHALL be 0.

Verification
REQ-032 The bench SHALL cover: req0 op=011, a=0x00F8, b=0x0147, rsp_ready=1 -> req0_ready at T; rsp_valid at T+2 with rsp_result=0xFE00, rsp_id=0, rsp_zero=0; op_count=1.
REQ-033 The bench SHALL cover: both requesters valid continuously after reset, req0 op=000 a=0xFFFF b=0x0F0F, req1 op=010 a=0xAAAA b=0xAAAA -> grant order 0,1,0,1; results alternate 0x0F0F and 0x0000, with rsp_zero=1 on the req1 results.
REQ-034 The bench SHALL cover: rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_result stable, both readies low, busy=1; release -> IDLE the next cycle.
REQ-035 The bench SHALL cover: after acceptance, req1 changes a from 0x1234 to 0xFFFF with op=111 -> rsp_result=0x1234.
REQ-036 The bench SHALL cover: rst_n low for one cycle while in RESP -> rsp_valid=0, op_count unchanged at its reset value 0, and the next contention is won by req0.
REQ-037 The bench SHALL cover: 65536 completed operations -> op_count wraps to 0x0000.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single-issue bitwise ALU.
// One operation is in flight at a time: accept (IDLE) -> compute (EXEC) -> hand back (RESP).
module alu_arbiter #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [2:0]      req0_op,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [2:0]      req1_op,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [SIZE-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            busy,
    output logic [15:0]     op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic            last_grant;
    logic            grant_any;
    logic            grant_id;
    logic [2:0]      op_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] alu_res;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant_any  = rst_n && (state == IDLE) && (req0_valid || req1_valid);
        grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any && grant_id;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_res = '0;
        case (op_q)
            3'b000:  alu_res = a_q & b_q;
            3'b001:  alu_res = a_q | b_q;
            3'b010:  alu_res = a_q ^ b_q;
            3'b011:  alu_res = ~(a_q | b_q);
            3'b100:  alu_res = ~(a_q & b_q);
            3'b101:  alu_res = ~(a_q ^ b_q);
            3'b110:  alu_res = ~a_q;
            default: alu_res = a_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            op_count   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state      <= EXEC;
                        last_grant <= grant_id;
                        rsp_id     <= grant_id;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_res;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state    <= IDLE;
                        op_count <= op_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on grant before EXEC reads them.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            op_q <= grant_id ? req1_op : req0_op;
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_zero  = (rsp_result == '0);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: inputs change on the falling edge, outputs are
// sampled 1 time unit later so combinational readies have settled.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [15:0] rsp_result, op_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_readies: got %b expected 00", {req1_ready, req0_ready});
        end
        @(negedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (op_count !== 16'h0000) begin n_fail++; $display("FAIL reset_op_count: got %h expected 0000", op_count); end
        n_checks++;
        if (rsp_result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", rsp_result); end
        n_checks++;
        if (rsp_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", rsp_zero); end
        n_checks++;
        if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b expected 0", rsp_id); end
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_readies_held: got %b expected 00", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 16'h00F8; req0_b = 16'h0147; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL single_exec: busy/rsp_valid got %b expected 10", {busy, rsp_valid});
        end
        @(negedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        n_checks++;
        if (rsp_result !== 16'hFE00) begin n_fail++; $display("FAIL single_result: got %h expected fe00", rsp_result); end
        n_checks++;
        if ({rsp_id, rsp_zero} !== 2'b00) begin
            n_fail++; $display("FAIL single_id_zero: got %b expected 00", {rsp_id, rsp_zero});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL single_idle: busy/rsp_valid got %b expected 00", {busy, rsp_valid});
        end
        n_checks++;
        if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_op_count: got %0d expected 1", op_count); end
    endtask

    task automatic test_opcodes;
        logic [15:0] exp_tab [8];
        exp_tab = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h000F, 16'h0FFF, 16'hF00F, 16'h00FF, 16'hFF00};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_op = 3'(i); req0_a = 16'hFF00; req0_b = 16'hF0F0; rsp_ready = 1'b1;
            @(negedge clk);
            req0_valid = 1'b0;
            @(negedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL opcode_%0d: valid=%b result=%h expected valid=1 result=%h", i, rsp_valid, rsp_result, exp_tab[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic e;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'hFFFF; req0_b = 16'h0F0F;
        req1_valid = 1'b1; req1_op = 3'b010; req1_a = 16'hAAAA; req1_b = 16'hAAAA;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = k[0];
            #1;
            n_checks++;
            if ({req1_ready, req0_ready} !== (e ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL b2b_grant_%0d: got %b expected %b", k, {req1_ready, req0_ready}, (e ? 2'b10 : 2'b01));
            end
            @(negedge clk);
            @(negedge clk); #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_zero} !== {1'b1, e, e}) begin
                n_fail++; $display("FAIL b2b_rsp_%0d: valid/id/zero got %b expected %b", k, {rsp_valid, rsp_id, rsp_zero}, {1'b1, e, e});
            end
            n_checks++;
            if (rsp_result !== (e ? 16'h0000 : 16'h0F0F)) begin
                n_fail++; $display("FAIL b2b_result_%0d: got %h expected %h", k, rsp_result, (e ? 16'h0000 : 16'h0F0F));
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_checks++;
        if (op_count !== 16'd4 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count: op_count=%0d busy=%b expected 4 and 0", op_count, busy);
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'h1200; req0_b = 16'h0034; rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL stall_grant: got %b expected 1", req0_ready); end
        @(negedge clk);
        req1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({rsp_valid, busy, req1_ready, req0_ready} !== 4'b1100 || rsp_result !== 16'h1234) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid/busy/rdy1/rdy0=%b result=%h expected 1100 and 1234",
                         c, {rsp_valid, busy, req1_ready, req0_ready}, rsp_result);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h1234) begin
            n_fail++; $display("FAIL stall_release: valid=%b result=%h expected 1 and 1234", rsp_valid, rsp_result);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({busy, rsp_valid} !== 2'b00 || op_count !== 16'd5) begin
            n_fail++; $display("FAIL stall_idle: busy/valid=%b op_count=%0d expected 00 and 5", {busy, rsp_valid}, op_count);
        end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL dropped_req_served: busy got %b expected 0", busy); end
    endtask

    task automatic test_operand_change;
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'b111; req1_a = 16'h1234; req1_b = 16'h0000; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL hold_grant: got %b expected 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
        @(negedge clk); #1;
        n_checks++;
        if (rsp_result !== 16'h1234 || rsp_id !== 1'b1) begin
            n_fail++; $display("FAIL hold_result: result=%h id=%b expected 1234 and 1", rsp_result, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_resp;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'hFFFF; req0_b = 16'hFFFF; rsp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL abort_in_resp: valid got %b expected 1", rsp_valid); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_zero} !== 3'b001 || op_count !== 16'd0) begin
            n_fail++; $display("FAIL abort_state: valid/busy/zero=%b op_count=%0d expected 001 and 0", {rsp_valid, busy, rsp_zero}, op_count);
        end
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 3'b111; req0_a = 16'h0055;
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL abort_priority: got %b expected 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (rsp_id !== 1'b0 || rsp_result !== 16'h0055) begin
            n_fail++; $display("FAIL abort_next_rsp: id=%b result=%h expected 0 and 0055", rsp_id, rsp_result);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 16'h0001; rsp_ready = 1'b1;
        repeat (3 * 65535) @(negedge clk);
        #1;
        n_checks++;
        if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h expected ffff", op_count); end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", op_count); end
        req0_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
        test_reset();
        test_single();
        test_opcodes();
        test_back_to_back();
        test_stall();
        test_operand_change();
        test_reset_in_resp();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
